// File: rtl/cfa_addr_gen_p.sv
// ROI scan address generator for CFA frames: raster or serpentine walk over
// rows rowMin..rowMax and columns colMin..colMax, one pixel per accepted en.
module cfa_addr_gen_p #(
   parameter int          ROW_W     = 11,
   parameter int          COL_W     = 11,
   parameter int          ADDR_W    = 22,
   parameter logic [1:0]  BAYER_PAT = 2'b00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ROW_W-1:0]  rowMin,
   input  logic [ROW_W-1:0]  rowMax,
   input  logic [COL_W-1:0]  colMin,
   input  logic [COL_W-1:0]  colMax,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] stride,
   input  logic              serp,
   input  logic              en,
   output logic [ADDR_W-1:0] address,
   output logic              addressValid,
   output logic              ready,
   output logic              rowUpdateFlag,
   output logic              colUpdateFlag,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col,
   output logic [1:0]        bayerPhase,
   output logic              frameDone
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EMPTY = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1'b1);
   localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1'b1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

   state_e              state_q, state_d;
   logic [ROW_W-1:0]    rowMax_q, rowMax_d;
   logic [COL_W-1:0]    colMin_q, colMin_d;
   logic [COL_W-1:0]    colMax_q, colMax_d;
   logic [ADDR_W-1:0]   stride_q, stride_d;
   logic [ADDR_W-1:0]   width_q, width_d;
   logic                serp_q, serp_d;
   logic                rev_q, rev_d;
   logic                odd_q, odd_d;
   logic [ADDR_W-1:0]   lineAddr_q, lineAddr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic                valid_q, valid_d;
   logic                ready_q, ready_d;
   logic                rowUpd_q, rowUpd_d;
   logic                colUpd_q, colUpd_d;
   logic [1:0]          phase_q, phase_d;
   logic                done_q, done_d;

   logic [COL_W-1:0]    width_s;
   logic [ADDR_W-1:0]   nextLine_s;
   logic                rowEnd_s;

   assign width_s    = colMax - colMin;
   assign nextLine_s = lineAddr_q + stride_q;
   // rev_q marks a right-to-left row, so its end is at colMin
   assign rowEnd_s   = rev_q ? (col_q == colMin_q) : (col_q == colMax_q);

   // Next-state and next-output computation
   always_comb begin
      state_d    = state_q;
      rowMax_d   = rowMax_q;
      colMin_d   = colMin_q;
      colMax_d   = colMax_q;
      stride_d   = stride_q;
      width_d    = width_q;
      serp_d     = serp_q;
      rev_d      = rev_q;
      odd_d      = odd_q;
      lineAddr_d = lineAddr_q;
      addr_d     = addr_q;
      row_d      = row_q;
      col_d      = col_q;
      valid_d    = valid_q;
      ready_d    = ready_q;
      rowUpd_d   = 1'b0;
      colUpd_d   = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            valid_d = 1'b0;
            if (start) begin
               rowMax_d = rowMax;
               colMin_d = colMin;
               colMax_d = colMax;
               stride_d = stride;
               width_d  = ADDR_W'(width_s);
               serp_d   = serp;
               ready_d  = 1'b0;
               if ((rowMax < rowMin) || (colMax < colMin)) begin
                  state_d = S_EMPTY;
               end else begin
                  state_d    = S_RUN;
                  valid_d    = 1'b1;
                  addr_d     = base;
                  lineAddr_d = base;
                  row_d      = rowMin;
                  col_d      = colMin;
                  rev_d      = 1'b0;
                  odd_d      = 1'b0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EMPTY: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         S_RUN: begin
            if (en) begin
               if (rowEnd_s) begin
                  if (row_q == rowMax_q) begin
                     state_d = S_DONE;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     row_d      = row_q + ROW_ONE;
                     lineAddr_d = nextLine_s;
                     odd_d      = ~odd_q;
                     rowUpd_d   = 1'b1;
                     // Entering an odd row offset in serpentine mode: start at colMax
                     if (serp_q && !odd_q) begin
                        rev_d  = 1'b1;
                        col_d  = colMax_q;
                        addr_d = nextLine_s + width_q;
                     end else begin
                        rev_d  = 1'b0;
                        col_d  = colMin_q;
                        addr_d = nextLine_s;
                     end
                  end
               end else begin
                  colUpd_d = 1'b1;
                  if (rev_q) begin
                     col_d  = col_q - COL_ONE;
                     addr_d = addr_q - ADDR_ONE;
                  end else begin
                     col_d  = col_q + COL_ONE;
                     addr_d = addr_q + ADDR_ONE;
                  end
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase

      phase_d = {row_d[0] ^ BAYER_PAT[1], col_d[0] ^ BAYER_PAT[0]};
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         rowMax_q   <= '0;
         colMin_q   <= '0;
         colMax_q   <= '0;
         stride_q   <= '0;
         width_q    <= '0;
         serp_q     <= 1'b0;
         rev_q      <= 1'b0;
         odd_q      <= 1'b0;
         lineAddr_q <= '0;
         addr_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         valid_q    <= 1'b0;
         ready_q    <= 1'b1;
         rowUpd_q   <= 1'b0;
         colUpd_q   <= 1'b0;
         phase_q    <= 2'b00;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rowMax_q   <= rowMax_d;
         colMin_q   <= colMin_d;
         colMax_q   <= colMax_d;
         stride_q   <= stride_d;
         width_q    <= width_d;
         serp_q     <= serp_d;
         rev_q      <= rev_d;
         odd_q      <= odd_d;
         lineAddr_q <= lineAddr_d;
         addr_q     <= addr_d;
         row_q      <= row_d;
         col_q      <= col_d;
         valid_q    <= valid_d;
         ready_q    <= ready_d;
         rowUpd_q   <= rowUpd_d;
         colUpd_q   <= colUpd_d;
         phase_q    <= phase_d;
         done_q     <= done_d;
      end
   end

   assign address       = addr_q;
   assign addressValid  = valid_q;
   assign ready         = ready_q;
   assign rowUpdateFlag = rowUpd_q;
   assign colUpdateFlag = colUpd_q;
   assign row           = row_q;
   assign col           = col_q;
   assign bayerPhase    = phase_q;
   assign frameDone     = done_q;

endmodule

// File: tb/tb_cfa_addr_gen_p.sv
// Randomised bench for cfa_addr_gen_p against an arithmetic pixel-list model.
module tb_cfa_addr_gen_p;

   localparam int         ROW_W  = 11;
   localparam int         COL_W  = 11;
   localparam int         ADDR_W = 22;
   localparam logic [1:0] PAT    = 2'b00;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [ROW_W-1:0]  rowMin = '0, rowMax = '0;
   logic [COL_W-1:0]  colMin = '0, colMax = '0;
   logic [ADDR_W-1:0] base = '0, stride = '0;
   logic              serp = 1'b0;
   logic              en = 1'b0;
   logic [ADDR_W-1:0] address;
   logic              addressValid, ready, rowUpdateFlag, colUpdateFlag, frameDone;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col;
   logic [1:0]        bayerPhase;

   int n_tests = 0;
   int n_fail  = 0;

   logic [ADDR_W-1:0] e_addr[$];
   int                e_row[$];
   int                e_col[$];
   int                e_k[$];
   logic [1:0]        e_ph[$];

   cfa_addr_gen_p #(.ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W), .BAYER_PAT(PAT)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rowMin(rowMin), .rowMax(rowMax), .colMin(colMin), .colMax(colMax),
      .base(base), .stride(stride), .serp(serp), .en(en),
      .address(address), .addressValid(addressValid), .ready(ready),
      .rowUpdateFlag(rowUpdateFlag), .colUpdateFlag(colUpdateFlag),
      .row(row), .col(col), .bayerPhase(bayerPhase), .frameDone(frameDone)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pixel list of the ROI in scan order, straight from the addressing formula
   task automatic build_model(input int rmin, input int rmax, input int cmin, input int cmax,
                              input longint b, input longint s, input bit sp);
      e_addr.delete(); e_row.delete(); e_col.delete(); e_k.delete(); e_ph.delete();
      for (int r = rmin; r <= rmax; r++) begin
         for (int k = 0; k <= cmax - cmin; k++) begin
            int     ro;
            int     c;
            longint a;
            logic [1:0] ph;
            ro = r - rmin;
            c  = (sp && (ro % 2 == 1)) ? (cmax - k) : (cmin + k);
            a  = (b + longint'(ro) * s + longint'(c - cmin)) % (longint'(1) << ADDR_W);
            ph = {r[0] ^ PAT[1], c[0] ^ PAT[0]};
            e_addr.push_back(ADDR_W'(a));
            e_row.push_back(r);
            e_col.push_back(c);
            e_k.push_back(k);
            e_ph.push_back(ph);
         end
      end
   endtask

   task automatic run_frame(input int rmin, input int rmax, input int cmin, input int cmax,
                            input longint b, input longint s, input bit sp,
                            input int stall_pct, input bit hold_start);
      int n, cur, cycles;
      bit prev_en;
      build_model(rmin, rmax, cmin, cmax, b, s, sp);
      @(negedge clk);
      rowMin = ROW_W'(rmin); rowMax = ROW_W'(rmax);
      colMin = COL_W'(cmin); colMax = COL_W'(cmax);
      base = ADDR_W'(b); stride = ADDR_W'(s); serp = sp;
      en = 1'b0; start = 1'b1;
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      n = e_addr.size();
      if (n == 0) begin
         check_val("empty_valid", addressValid, 1'b0);
         check_val("empty_ready", ready, 1'b0);
         check_val("empty_done0", frameDone, 1'b0);
         @(negedge clk);
         check_val("empty_done", frameDone, 1'b1);
         check_val("empty_valid2", addressValid, 1'b0);
         @(negedge clk);
         check_val("empty_done_end", frameDone, 1'b0);
         check_val("empty_ready_back", ready, 1'b1);
         return;
      end
      cur = 0; cycles = 0; prev_en = 1'b0;
      while (cur < n && cycles < n * 10 + 20) begin
         check_val("valid", addressValid, 1'b1);
         check_val("ready_low", ready, 1'b0);
         check_val("addr", address, e_addr[cur]);
         check_val("row", row, e_row[cur]);
         check_val("col", col, e_col[cur]);
         check_val("phase", bayerPhase, e_ph[cur]);
         check_val("rowflag", rowUpdateFlag, prev_en && cur > 0 && e_k[cur] == 0);
         check_val("colflag", colUpdateFlag, prev_en && cur > 0 && e_k[cur] != 0);
         check_val("done_low", frameDone, 1'b0);
         en = ($urandom_range(99) >= stall_pct);
         prev_en = en;
         if (en) cur++;
         @(negedge clk);
         cycles++;
      end
      en = 1'b0;
      if (cur < n) check_val("timeout", 1'b1, 1'b0);
      check_val("end_valid", addressValid, 1'b0);
      check_val("end_done", frameDone, 1'b1);
      check_val("end_ready", ready, 1'b0);
      @(negedge clk);
      check_val("idle_ready", ready, 1'b1);
      check_val("idle_done", frameDone, 1'b0);
      if (hold_start) begin
         @(negedge clk);
         start = 1'b0;
         check_val("restart_valid", addressValid, 1'b1);
         check_val("restart_addr", address, e_addr[0]);
         en = 1'b1;
         cycles = 0;
         while (!frameDone && cycles < n + 10) begin
            @(negedge clk);
            cycles++;
         end
         en = 1'b0;
         check_val("restart_done", frameDone, 1'b1);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_val("rst_ready", ready, 1'b1);
      check_val("rst_valid", addressValid, 1'b0);
      check_val("rst_addr", address, 0);
      check_val("rst_rowcol", {row, col}, 0);
      check_val("rst_phase", bayerPhase, 0);
      check_val("rst_flags", {rowUpdateFlag, colUpdateFlag, frameDone}, 0);
      rst = 1'b1;

      run_frame(0, 7, 0, 7, 0, 8, 1'b0, 0, 1'b0);
      run_frame(2, 3, 4, 6, 100, 1920, 1'b1, 0, 1'b0);
      run_frame(1, 3, 0, 9, 500, 40, 1'b0, 40, 1'b0);
      run_frame(5, 4, 0, 3, 0, 8, 1'b0, 0, 1'b0);
      run_frame(0, 0, 0, 3, 22'h3FFFFE, 8, 1'b0, 0, 1'b0);
      run_frame(3, 6, 7, 7, 10, 3, 1'b1, 30, 1'b0);
      run_frame(9, 9, 9, 9, 77, 3, 1'b0, 50, 1'b0);
      run_frame(2046, 2047, 2045, 2047, 22'h3FFFF0, 5, 1'b1, 20, 1'b0);
      run_frame(0, 1, 0, 2, 33, 16, 1'b1, 0, 1'b1);

      // Abort a frame in row 3 by asserting reset between clock edges
      build_model(0, 7, 0, 7, 50, 8, 1'b0);
      @(negedge clk);
      rowMin = '0; rowMax = ROW_W'(7); colMin = '0; colMax = COL_W'(7);
      base = ADDR_W'(50); stride = ADDR_W'(8); serp = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; en = 1'b1;
      repeat (24) @(negedge clk);
      check_val("abort_row", row, 3);
      #2 rst = 1'b0;
      #1;
      check_val("abort_ready", ready, 1'b1);
      check_val("abort_valid", addressValid, 1'b0);
      check_val("abort_addr", address, 0);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("abort_nodone", frameDone, 1'b0);
         check_val("abort_idle", ready, 1'b1);
      end
      run_frame(0, 7, 0, 7, 50, 8, 1'b0, 10, 1'b0);

      for (int t = 0; t < 14; t++) begin
         int rmin, cmin;
         rmin = $urandom_range(20);
         cmin = $urandom_range(20);
         run_frame(rmin, rmin + $urandom_range(5) - 1, cmin, cmin + $urandom_range(6) - 1,
                   longint'($urandom_range(32'h3FFFFF)), longint'($urandom_range(4000)),
                   1'($urandom_range(1)), $urandom_range(50), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cfa_addr_gen_p.md
Name: cfa_addr_gen_p

Overview:
- Parametrised successor to the CFA frame addressing logic.
- Scans a programmable region of interest (rowMin..rowMax, colMin..colMax) in raster or serpentine order.
- Emits a linear buffer address as base + (row-rowMin)*stride + (col-colMin), plus row/col coordinates, update flags and the Bayer phase of each pixel.
- Sits between the frame controller (start/ready handshake) and the line-buffer/memory read port (en advance).

Parameters:
- ROW_W, 11, row coordinate width.
- COL_W, 11, column coordinate width.
- ADDR_W, 22, address, base and stride width.
- BAYER_PAT, 2'b00, CFA phase of pixel (0,0); bit1 = row parity offset, bit0 = column parity offset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  frame request; accepted only when ready=1.
- rowMin  in  ROW_W  first row of the ROI.
- rowMax  in  ROW_W  last row of the ROI, inclusive.
- colMin  in  COL_W  first column of the ROI.
- colMax  in  COL_W  last column of the ROI, inclusive.
- base  in  ADDR_W  address of pixel (rowMin,colMin).
- stride  in  ADDR_W  address increment per row.
- serp  in  1  0 = raster; 1 = serpentine (odd row offsets scan right-to-left).
- en  in  1  consumer accepts the current address; advance.
- address  out  ADDR_W  current linear address.
- addressValid  out  1  address/row/col are valid.
- ready  out  1  idle; start will be accepted.
- rowUpdateFlag  out  1  first address of a new row (not the first row).
- colUpdateFlag  out  1  new address within the same row.
- row  out  ROW_W  current row.
- col  out  COL_W  current column.
- bayerPhase  out  2  {row[0]^BAYER_PAT[1], col[0]^BAYER_PAT[0]}.
- frameDone  out  1  one-cycle pulse after the last address is consumed.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) forces state IDLE:
  - ready=1.
  - address, row, col, bayerPhase = 0.
  - addressValid, flags, frameDone = 0.
- Reset mid-frame aborts immediately; no frameDone is produced.

States:
- IDLE:
  - ready=1.
  - On start=1, latch rowMin, rowMax, colMin, colMax, base, stride and serp; ready falls next cycle.
  - If rowMax<rowMin or colMax<colMin, go to DONE (no addresses are produced). Otherwise go to RUN.
  - Inputs are not sampled again until the next IDLE.
- RUN:
  - addressValid=1.
  - First cycle presents row=rowMin, col=colMin, address=base. Latency from start to first valid address is 1 cycle.
  - en=0: hold all outputs; flags drop to 0.
  - en=1 advances one pixel per cycle:
    - Within a row: col steps +1 (forward) or -1 (reverse); address steps by the same ±1; colUpdateFlag=1 with the new output.
    - At row end (col==colMax forward, or col==colMin reverse), if row<rowMax:
      - row+1; lineAddr += stride.
      - Raster, or even row offset: col=colMin, address=lineAddr.
      - Serpentine, odd row offset: col=colMax, address=lineAddr+(colMax-colMin).
      - rowUpdateFlag=1 and colUpdateFlag=0 with the new output.
    - At row end with row==rowMax: go to DONE.
- DONE:
  - Lasts one cycle: addressValid=0, frameDone=1.
  - Then IDLE with ready=1 on the following cycle.
  - start is ignored during RUN and DONE.

Arithmetic and width rules:
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- No multiplier: a line-start accumulator (lineAddr) is used.
- The width term (colMax-colMin) is computed at start latch, zero-extended to ADDR_W.

Boundary conditions:
- Single-column ROI: every en=1 is a row change.
- Single-pixel ROI: RUN lasts until the first en=1, then DONE.
- start held high continuously starts a new frame in the first IDLE cycle after DONE.
- rowMax/colMax equal to the all-ones value must not overflow the counters: compare before incrementing.

Test Plan:
- Raster, rowMin=0, rowMax=7, colMin=0, colMax=7, base=0, stride=8, serp=0, en=1, start pulse:
  - 64 consecutive valid addresses 0..63.
  - rowUpdateFlag at addresses 8, 16, …, 56.
  - frameDone 1 cycle after address 63; ready=1 the cycle after that.
- ROI rows 2..3, cols 4..6, base=100, stride=1920, serp=1:
  - Address sequence 100, 101, 102, 2022, 2021, 2020.
  - col sequence 4, 5, 6, 6, 5, 4.
  - bayerPhase with BAYER_PAT=0: 00, 01, 00, 10, 11, 10.
- Stall: en toggled 1,0,0,1 during a row:
  - address, row and col hold through the en=0 cycles.
  - colUpdateFlag=0 during stalls.
  - Total valid addresses still equals the ROI size.
- Degenerate ROI (rowMin=5, rowMax=4):
  - No addressValid.
  - frameDone pulse 2 cycles after start; ready returns.
- Reset asserted mid-frame (row=3):
  - Immediately ready=1, addressValid=0, address=0.
  - No frameDone.
  - A new start after reset release begins at base.
- Wrap: base=22'h3FFFFE, 1x4 ROI → addresses 3FFFFE, 3FFFFF, 000000, 000001.
